mux_sel_pipe: RTL

Parametrised, pipelined operand selector for the MUSA datapath: picks one of N_IN WIDTH-bit sources by a select code and delivers it through a registered valid/ready stage. It replaces the fixed 18-bit, six-source combinational selectors with one block. The block has configurable legal-code masking, an illegal-select error output, a saturating error counter and an optional skid buffer. It sits between the register-file/immediate sources and the ALU operand inputs.

---
 rtl/mux_sel_pipe.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - pipelined N_IN-way operand selector with illegal-code flagging
// Optional skid buffer: define MUX_SEL_SKID_EN to add a second storage entry and
// a registered in_ready (no combinational out_ready -> in_ready path).
module mux_sel_pipe #(
    parameter int              WIDTH      = 18,
    parameter int              N_IN       = 8,
    parameter logic [N_IN-1:0] LEGAL_MASK = 8'b0111_0111,
    parameter int              ERR_CNT_W  = 8,
    parameter int              SEL_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

`ifdef MUX_SEL_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;
`else
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE} state_t;
`endif

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      out_data_q;
    logic                  out_err_q;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic                  sel_legal;
    logic [WIDTH-1:0]      sel_data;
    logic [WIDTH-1:0]      new_data;
    logic                  new_err;
    logic                  accept;
    logic                  retire;
    logic                  load_out_new;

`ifdef MUX_SEL_SKID_EN
    logic [WIDTH-1:0]      skid_data_q;
    logic                  skid_err_q;
    logic                  in_ready_q;
    logic                  load_out_skid;
    logic                  load_skid;
`endif

    // Decode the select code; codes beyond N_IN-1 fall through as illegal
    always_comb begin
        sel_legal = 1'b0;
        sel_data  = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_legal = LEGAL_MASK[k];
                sel_data  = in_data[k*WIDTH +: WIDTH];
            end
        end
        new_data = sel_legal ? sel_data : '0;
        new_err  = !sel_legal;
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;
    assign retire    = out_valid && out_ready;
    assign accept    = in_valid && in_ready;

`ifdef MUX_SEL_SKID_EN
    // Ready comes from a flop so the consumer's ready never reaches the producer
    assign in_ready = in_ready_q && !rst;
`else
    assign in_ready = !rst && (!out_valid || out_ready);
`endif

    // Next-state and load-enable decode for the storage entries
    always_comb begin
        state_d      = state_q;
        load_out_new = 1'b0;
`ifdef MUX_SEL_SKID_EN
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_ONE;
                    load_out_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && retire) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
`ifdef MUX_SEL_SKID_EN
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
`endif
                end else if (retire) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef MUX_SEL_SKID_EN
            ST_TWO: begin
                if (retire) begin
                    state_d       = ST_ONE;
                    load_out_skid = 1'b1;
                end
            end
`endif
            default: state_d = ST_EMPTY;
        endcase
    end

    // Saturating count of accepted illegal-code beats
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && new_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State, output register and error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            err_cnt_q <= err_cnt_d;
            if (load_out_new) begin
                out_data_q <= new_data;
                out_err_q  <= new_err;
            end
`ifdef MUX_SEL_SKID_EN
            else if (load_out_skid) begin
                out_data_q <= skid_data_q;
                out_err_q  <= skid_err_q;
            end
`endif
        end
    end

`ifdef MUX_SEL_SKID_EN
    // Skid entry and registered ready: ready drops only once both entries are full
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            in_ready_q <= (state_d != ST_TWO);
            if (load_skid) begin
                skid_data_q <= new_data;
                skid_err_q  <= new_err;
            end
        end
    end
`endif

endmodule
